// File: rtl/ras_ctrl.sv
// ras_ctrl: decodes call/return into RAS push/pop (issued 1 cycle after accept), logs speculative ops, undoes them youngest-first on flush.
// Backpressure: if_ready low while repairing, during flush, or when log+stage would exceed LOG_DEPTH. RV32C decode under RAS_CTRL_RVC_EN.
module ras_ctrl #(
  parameter int LOG_DEPTH = 8,
  parameter bit LINK_X5   = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  input  logic        commit,
  input  logic        flush,
  output logic        ras_push,
  output logic        ras_pop,
  output logic [31:0] ras_din,
  input  logic [31:0] ras_dout,
  output logic        pred_valid,
  output logic [31:0] pred_target,
  output logic        busy
);

  localparam int LW = $clog2(LOG_DEPTH);
  localparam int CW = LW + 1;

  typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_POP, OP_BOTH} op_t;
  typedef enum logic {IDLE, REPAIR} state_t;

  state_t        state, state_n;
  logic          stage_vld;
  op_t           stage_op;
  logic [31:0]   stage_link;
  op_t           log_op    [LOG_DEPTH];
  logic [31:0]   log_saved [LOG_DEPTH];
  logic [LW-1:0] wr_ptr, yng_ptr;
  logic [CW-1:0] log_count;
  op_t           dec_op;
  logic [31:0]   dec_link;
  logic          rd_l, rs1_l;
  logic          accept, issue, retire, undo;
  logic          unused_bits;

  assign unused_bits = ^{if_inst[31:20], if_inst[14:12]};

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (LINK_X5 && (r == 5'd5));
  endfunction

  always_comb begin
    dec_op   = OP_NONE;
    dec_link = if_pc + 32'd4;
    rd_l     = is_link(if_inst[11:7]);
    rs1_l    = is_link(if_inst[19:15]);
    case (if_inst[6:0])
      7'b1101111: if (rd_l) dec_op = OP_PUSH;
      7'b1100111: begin
        if (rd_l && rs1_l)
          dec_op = (if_inst[11:7] != if_inst[19:15]) ? OP_BOTH : OP_PUSH;
        else if (rd_l)
          dec_op = OP_PUSH;
        else if (rs1_l)
          dec_op = OP_POP;
      end
      default: ;
    endcase
`ifdef RAS_CTRL_RVC_EN
    // Compressed encodings override the 32-bit decode and link past a 2-byte instruction
    if (if_inst[1:0] != 2'b11) begin
      dec_op   = OP_NONE;
      dec_link = if_pc + 32'd2;
      if (if_inst[15:13] == 3'b001 && if_inst[1:0] == 2'b01)
        dec_op = OP_PUSH;
      else if (if_inst[15:12] == 4'b1001 && if_inst[6:2] == 5'd0 &&
               if_inst[11:7] != 5'd0 && if_inst[1:0] == 2'b10)
        dec_op = OP_PUSH;
      else if (if_inst[15:12] == 4'b1000 && if_inst[6:2] == 5'd0 &&
               is_link(if_inst[11:7]) && if_inst[1:0] == 2'b10)
        dec_op = OP_POP;
    end
`endif
  end

  assign if_ready = (state == IDLE) && !flush &&
                    ((32'(log_count) + 32'(stage_vld)) < LOG_DEPTH);
  assign accept   = if_valid && if_ready;
  assign issue    = (state == IDLE) && stage_vld && !flush;
  assign retire   = (state == IDLE) && commit && (log_count != '0);
  assign undo     = (state == REPAIR);
  assign yng_ptr  = wr_ptr - LW'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    ras_din     = '0;
    pred_valid  = 1'b0;
    pred_target = '0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          case (stage_op)
            OP_PUSH: begin
              ras_push = 1'b1;
              ras_din  = stage_link;
            end
            OP_POP: begin
              ras_pop     = 1'b1;
              pred_valid  = 1'b1;
              pred_target = ras_dout;
            end
            OP_BOTH: begin
              ras_push    = 1'b1;
              ras_pop     = 1'b1;
              ras_din     = stage_link;
              pred_valid  = 1'b1;
              pred_target = ras_dout;
            end
            default: ;
          endcase
        end
        // A same-cycle commit retires first; only a non-empty remainder needs repair
        if (flush && ((log_count - CW'(retire)) != '0)) state_n = REPAIR;
      end
      REPAIR: begin
        busy = 1'b1;
        case (log_op[yng_ptr])
          OP_PUSH: ras_pop = 1'b1;
          OP_POP: begin
            ras_push = 1'b1;
            ras_din  = log_saved[yng_ptr];
          end
          OP_BOTH: begin
            ras_push = 1'b1;
            ras_pop  = 1'b1;
            ras_din  = log_saved[yng_ptr];
          end
          default: ;
        endcase
        if (log_count == CW'(1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Oldest entry sits at wr_ptr - log_count, so commit only needs to shrink the count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage_vld  <= 1'b0;
      stage_op   <= OP_NONE;
      stage_link <= '0;
      wr_ptr     <= '0;
      log_count  <= '0;
      for (int i = 0; i < LOG_DEPTH; i++) begin
        log_op[i]    <= OP_NONE;
        log_saved[i] <= '0;
      end
    end else begin
      stage_vld <= accept && (dec_op != OP_NONE);
      if (accept) begin
        stage_op   <= dec_op;
        stage_link <= dec_link;
      end
      if (issue) begin
        log_op[wr_ptr]    <= stage_op;
        log_saved[wr_ptr] <= (stage_op == OP_PUSH) ? 32'd0 : ras_dout;
        wr_ptr            <= wr_ptr + LW'(1);
      end else if (undo) begin
        wr_ptr <= yng_ptr;
      end
      log_count <= log_count + CW'(issue) - CW'(retire) - CW'(undo);
    end
  end

endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl: directed scenarios plus randomized traffic against a queue-based reference model and a bench-owned RAS.
module tb_ras_ctrl;

  logic        clk, rstn, if_valid, if_ready, commit, flush;
  logic        ras_push, ras_pop, pred_valid, busy;
  logic [31:0] if_pc, if_inst, ras_din, ras_dout, pred_target;

  ras_ctrl #(.LOG_DEPTH(8), .LINK_X5(1'b1)) dut (
    .clk(clk), .rstn(rstn), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_inst(if_inst), .commit(commit), .flush(flush),
    .ras_push(ras_push), .ras_pop(ras_pop), .ras_din(ras_din), .ras_dout(ras_dout),
    .pred_valid(pred_valid), .pred_target(pred_target), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam int K_NONE = 0, K_PUSH = 1, K_POP = 2, K_BOTH = 3;
  localparam logic [31:0] I_CALL = 32'h000000EF;  // jal x1
  localparam logic [31:0] I_RET  = 32'h00008067;  // jalr x0, 0(x1)

  int nvec, nerr;
  logic [31:0] stk[$], cstk[$];          // live RAS contents, and contents implied by committed ops only
  bit          m_rep, m_stage, rep_done;
  int          m_stage_op;
  logic [31:0] m_stage_link;
  int          lq_op[$];
  logic [31:0] lq_saved[$], lq_link[$];
  bit          exp_ready, exp_push, exp_pop, exp_pv, exp_busy;
  logic [31:0] exp_din, exp_pt;
  logic        obs_ready, obs_push, obs_pop, obs_pv, obs_busy;
  logic [31:0] obs_din, obs_pt;

  function automatic int ref_op(input logic [31:0] inst);
    logic [4:0] rd, rs1;
    bit rdl, rsl;
    rd  = inst[11:7];
    rs1 = inst[19:15];
    rdl = (rd == 5'd1) || (rd == 5'd5);
    rsl = (rs1 == 5'd1) || (rs1 == 5'd5);
    if (inst[6:0] == 7'b1101111) return rdl ? K_PUSH : K_NONE;
    if (inst[6:0] == 7'b1100111) begin
      if (rdl && !rsl) return K_PUSH;
      if (!rdl && rsl) return K_POP;
      if (rdl && rsl) return (rd != rs1) ? K_BOTH : K_PUSH;
    end
    return K_NONE;
  endfunction

  function automatic logic [4:0] pick_reg();
    case ($urandom % 5)
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd5;
      3: return 5'd2;
      default: return 5'd6;
    endcase
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom % 6)
      0: return {r[31:12], pick_reg(), 7'b1101111};
      1, 2: return {r[31:20], pick_reg(), 3'b000, pick_reg(), 7'b1100111};
      3: return {r[31:7], 7'b0110011};
      4: return {r[31:2], 2'b01};
      default: return I_RET;
    endcase
  endfunction

  function automatic bit stk_match();
    if (stk.size() != cstk.size()) return 1'b0;
    foreach (stk[i]) if (stk[i] !== cstk[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_rep = 0; m_stage = 0;
    lq_op.delete(); lq_saved.delete(); lq_link.delete();
    cstk = stk;
  endtask

  task automatic set_in(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                        input bit cm, input bit fl);
    if_valid = v; if_pc = pc; if_inst = inst; commit = cm; flush = fl;
  endtask

  task automatic do_reset();
    stk.delete();
    rstn = 1'b0;
    ras_dout = 32'd0;
    set_in(0, 32'd0, 32'd0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    model_reset();
  endtask

  // One clock: model predicts, DUT is sampled mid-cycle, then the bench RAS applies the DUT's command
  task automatic step();
    logic [31:0] dout, sv, lk;
    int op;
    dout = (stk.size() > 0) ? stk[stk.size()-1] : 32'd0;
    ras_dout = dout;
    #3;
    exp_push = 0; exp_pop = 0; exp_pv = 0; exp_din = 0; exp_pt = 0;
    rep_done = 0;
    exp_busy  = m_rep;
    exp_ready = !m_rep && !flush && (lq_op.size() + int'(m_stage) < 8);
    if (m_rep) begin
      op = lq_op.pop_back(); sv = lq_saved.pop_back(); lk = lq_link.pop_back();
      exp_push = (op != K_PUSH);
      exp_pop  = (op != K_POP);
      exp_din  = sv;
      if (lq_op.size() == 0) begin m_rep = 0; rep_done = 1; end
    end else begin
      if (commit && lq_op.size() > 0) begin
        if (lq_op[0] == K_PUSH) cstk.push_back(lq_link[0]);
        else if (lq_op[0] == K_POP) void'(cstk.pop_back());
        else cstk[cstk.size()-1] = lq_link[0];
        lq_op.delete(0); lq_saved.delete(0); lq_link.delete(0);
      end
      if (m_stage && !flush) begin
        exp_push = (m_stage_op != K_POP);
        exp_pop  = (m_stage_op != K_PUSH);
        exp_din  = m_stage_link;
        exp_pv   = (m_stage_op != K_PUSH);
        exp_pt   = dout;
        lq_op.push_back(m_stage_op);
        lq_saved.push_back((m_stage_op == K_PUSH) ? 32'd0 : dout);
        lq_link.push_back(m_stage_link);
      end
      m_stage = 0;
      if (if_valid && exp_ready && ref_op(if_inst) != K_NONE) begin
        m_stage = 1; m_stage_op = ref_op(if_inst); m_stage_link = if_pc + 32'd4;
      end
      if (flush) begin
        if (lq_op.size() > 0) m_rep = 1;
        else rep_done = 1;
      end
    end
    obs_ready = if_ready; obs_push = ras_push; obs_pop = ras_pop; obs_din = ras_din;
    obs_pv = pred_valid; obs_pt = pred_target; obs_busy = busy;
    @(posedge clk);
    #1;
    if (obs_push && obs_pop) begin
      if (stk.size() > 0) stk[stk.size()-1] = obs_din; else stk.push_back(obs_din);
    end else if (obs_push) stk.push_back(obs_din);
    else if (obs_pop && stk.size() > 0) void'(stk.pop_back());
    ras_dout = (stk.size() > 0) ? stk[stk.size()-1] : 32'd0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    ras_dout = 32'd0;
    set_in(0, 32'd0, 32'd0, 0, 0);
    #1;
    nvec++;
    if ({if_ready, ras_push, ras_pop, pred_valid, busy} !== 5'b10000 || ras_din !== 32'd0 || pred_target !== 32'd0) begin
      nerr++;
      $display("FAIL reset_outputs: rdy/push/pop/pv/busy=%b din=%h pt=%h, want 10000 0 0",
               {if_ready, ras_push, ras_pop, pred_valid, busy}, ras_din, pred_target);
    end
    do_reset();
    set_in(0, 32'd0, 32'd0, 0, 0);
    step();
    nvec++;
    if (obs_ready !== 1'b1 || obs_push !== 1'b0 || obs_pop !== 1'b0 || obs_busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_idle: rdy=%b push=%b pop=%b busy=%b, want 1 0 0 0", obs_ready, obs_push, obs_pop, obs_busy);
    end
  endtask

  task automatic test_call_commit();
    do_reset();
    set_in(1, 32'h1000, I_CALL, 0, 0); step();
    set_in(0, 32'd0, 32'd0, 0, 0);     step();
    nvec++;
    if (obs_push !== 1'b1 || obs_pop !== 1'b0 || obs_din !== 32'h1004) begin
      nerr++;
      $display("FAIL call_push: push=%b pop=%b din=%h, want 1 0 00001004", obs_push, obs_pop, obs_din);
    end
    nvec++;
    if (dut.log_count !== 4'd1) begin
      nerr++; $display("FAIL call_logcount: got %0d want 1", dut.log_count);
    end
    set_in(0, 32'd0, 32'd0, 1, 0); step();
    nvec++;
    if (dut.log_count !== 4'd0) begin
      nerr++; $display("FAIL commit_logcount: got %0d want 0", dut.log_count);
    end
  endtask

  task automatic test_return();
    set_in(1, 32'h2000, I_RET, 0, 0); step();
    set_in(0, 32'd0, 32'd0, 0, 0);    step();
    nvec++;
    if (obs_pop !== 1'b1 || obs_push !== 1'b0 || obs_pv !== 1'b1 || obs_pt !== 32'h1004) begin
      nerr++;
      $display("FAIL return_pred: pop=%b push=%b pv=%b pt=%h, want 1 0 1 00001004", obs_pop, obs_push, obs_pv, obs_pt);
    end
    set_in(0, 32'd0, 32'd0, 1, 0); step();
  endtask

  task automatic test_flush_repair();
    bit          ep [3] = '{1'b1, 1'b0, 1'b0};
    bit          eq [3] = '{1'b0, 1'b1, 1'b1};
    do_reset();
    set_in(1, 32'h100, I_CALL, 0, 0); step();
    set_in(1, 32'h200, I_CALL, 0, 0); step();
    set_in(1, 32'h300, I_RET, 0, 0);  step();
    set_in(0, 32'd0, 32'd0, 0, 0);    step();
    set_in(0, 32'd0, 32'd0, 0, 1);    step();
    set_in(0, 32'd0, 32'd0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      nvec++;
      if (obs_busy !== 1'b1 || obs_pv !== 1'b0 || obs_push !== ep[k] || obs_pop !== eq[k] ||
          (ep[k] && obs_din !== 32'h204)) begin
        nerr++;
        $display("FAIL repair_cycle%0d: busy=%b pv=%b push=%b pop=%b din=%h, want 1 0 %b %b 00000204",
                 k, obs_busy, obs_pv, obs_push, obs_pop, obs_din, ep[k], eq[k]);
      end
    end
    step();
    nvec++;
    if (obs_busy !== 1'b0 || obs_ready !== 1'b1 || stk.size() != 0) begin
      nerr++;
      $display("FAIL repair_end: busy=%b rdy=%b stack_depth=%0d, want 0 1 0", obs_busy, obs_ready, stk.size());
    end
  endtask

  task automatic test_full_log();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_in(1, 32'h1000 + 32'(16 * i), I_CALL, 0, 0); step();
      nvec++;
      if (obs_ready !== 1'b1) begin nerr++; $display("FAIL fill_ready%0d: got %b want 1", i, obs_ready); end
    end
    set_in(1, 32'h3000, I_CALL, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      nvec++;
      if (obs_ready !== 1'b0) begin nerr++; $display("FAIL full_held%0d: rdy got %b want 0", i, obs_ready); end
    end
    commit = 1'b1; step();
    nvec++;
    if (obs_ready !== 1'b0) begin nerr++; $display("FAIL full_commit_cycle: rdy got %b want 0", obs_ready); end
    commit = 1'b0; step();
    nvec++;
    if (obs_ready !== 1'b1) begin nerr++; $display("FAIL after_commit_ready: rdy got %b want 1", obs_ready); end
    set_in(0, 32'd0, 32'd0, 0, 0); step();
    nvec++;
    if (obs_push !== 1'b1 || obs_din !== 32'h3004) begin
      nerr++; $display("FAIL ninth_call: push=%b din=%h, want 1 00003004", obs_push, obs_din);
    end
  endtask

  task automatic test_commit_flush();
    int npop, npush, nbusy;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 32'h400 + 32'(256 * i), I_CALL, 0, 0); step();
    end
    set_in(0, 32'd0, 32'd0, 0, 0); step();
    set_in(0, 32'd0, 32'd0, 1, 1); step();
    set_in(0, 32'd0, 32'd0, 0, 0);
    npop = 0; npush = 0; nbusy = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (obs_busy) begin
        nbusy++;
        if (obs_pop) npop++;
        if (obs_push) npush++;
      end
    end
    nvec++;
    if (npop != 2 || npush != 0 || nbusy != 2) begin
      nerr++; $display("FAIL commit_flush_undo: pops=%0d pushes=%0d busy=%0d, want 2 0 2", npop, npush, nbusy);
    end
    nvec++;
    if (stk.size() != 1 || stk[0] !== 32'h404) begin
      nerr++; $display("FAIL commit_flush_stack: depth=%0d, want 1 holding 00000404", stk.size());
    end
  endtask

  task automatic test_reset_mid_repair();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 32'h700 + 32'(16 * i), I_CALL, 0, 0); step();
    end
    set_in(0, 32'd0, 32'd0, 0, 0); step();
    set_in(0, 32'd0, 32'd0, 0, 1); step();
    set_in(0, 32'd0, 32'd0, 0, 0); step();
    nvec++;
    if (busy !== 1'b1 || ras_pop !== 1'b1) begin
      nerr++; $display("FAIL second_repair_cycle: busy=%b pop=%b, want 1 1", busy, ras_pop);
    end
    rstn = 1'b0;
    #1;
    nvec++;
    if (ras_push !== 1'b0 || ras_pop !== 1'b0 || busy !== 1'b0 || if_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_abort: push=%b pop=%b busy=%b rdy=%b, want 0 0 0 1", ras_push, ras_pop, busy, if_ready);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    model_reset();
    nvec++;
    if (dut.log_count !== 4'd0) begin nerr++; $display("FAIL reset_abort_log: count %0d want 0", dut.log_count); end
    set_in(0, 32'd0, 32'd0, 0, 1); step();
    set_in(0, 32'd0, 32'd0, 0, 0); step();
    nvec++;
    if (obs_busy !== 1'b0 || obs_ready !== 1'b1) begin
      nerr++; $display("FAIL reset_abort_flush: busy=%b rdy=%b, want 0 1", obs_busy, obs_ready);
    end
  endtask

  task automatic test_random();
    logic [31:0] inst, pc;
    int op;
    bit fl;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      inst = gen_inst();
      op = ref_op(inst);
      // Keep the stack from underflowing so a repair must restore it exactly
      if ((op == K_POP || op == K_BOTH) && stk.size() < 2) inst = 32'h00000013;
      pc = ($urandom % 8 == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
      fl = (m_rep || !m_stage) && ($urandom % 20 == 0);
      set_in($urandom % 4 != 0, pc, inst, $urandom % 3 == 0, fl);
      step();
      nvec++;
      if (obs_ready !== exp_ready || obs_push !== exp_push || obs_pop !== exp_pop || obs_pv !== exp_pv ||
          obs_busy !== exp_busy || (exp_push && obs_din !== exp_din) || (exp_pv && obs_pt !== exp_pt)) begin
        nerr++;
        $display("FAIL random_cyc%0d: got rdy%b push%b pop%b din%h pv%b pt%h busy%b, want rdy%b push%b pop%b din%h pv%b pt%h busy%b",
                 c, obs_ready, obs_push, obs_pop, obs_din, obs_pv, obs_pt, obs_busy,
                 exp_ready, exp_push, exp_pop, exp_din, exp_pv, exp_pt, exp_busy);
      end
      if (rep_done) begin
        nvec++;
        if (!stk_match()) begin
          nerr++; $display("FAIL random_restore_cyc%0d: stack depth %0d, committed depth %0d", c, stk.size(), cstk.size());
        end
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_call_commit();
    test_return();
    test_flush_repair();
    test_full_log();
    test_commit_flush();
    test_reset_mid_repair();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
